mc_ctrl_ws: RTL

MC_CTRL_WS -- requirements
Module: mc_ctrl_ws

---
 rtl/mc_ctrl_ws.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/mc_ctrl_ws.sv
// mc_ctrl_ws: multicycle MIPS-style control FSM with memory wait states.
// Fetch and data accesses stall until mem_ready; a stall lasting
// 2^WAIT_W-1 cycles, or an illegal instruction (EXC_EN=1), parks the
// controller in TRAP until reset.
module mc_ctrl_ws #(
    parameter int unsigned WAIT_W = 4,
    parameter bit          EXC_EN = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       ALUSrcA,
    output logic       RegWrite,
    output logic [1:0] PCSource,
    output logic [1:0] ALUOp,
    output logic [1:0] ALUSrcB,
    output logic [1:0] RegDst,
    output logic [1:0] MemtoReg,
    output logic       trap,
    output logic       busy_wait,
    output logic [3:0] state
);

    localparam logic [3:0] FETCH  = 4'd0;
    localparam logic [3:0] DECODE = 4'd1;
    localparam logic [3:0] MEMADR = 4'd2;
    localparam logic [3:0] MEMRD  = 4'd3;
    localparam logic [3:0] MEMWB  = 4'd4;
    localparam logic [3:0] MEMWR  = 4'd5;
    localparam logic [3:0] EXEC   = 4'd6;
    localparam logic [3:0] ALUWB  = 4'd7;
    localparam logic [3:0] BEQ    = 4'd8;
    localparam logic [3:0] BNE    = 4'd9;
    localparam logic [3:0] JUMP   = 4'd10;
    localparam logic [3:0] JR     = 4'd11;
    localparam logic [3:0] JAL    = 4'd12;
    localparam logic [3:0] TRAP   = 4'd15;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] FN_JR    = 6'b001000;

    localparam logic [WAIT_W-1:0] WAIT_ALL  = '1;
    // Counter value during the last tolerated stall cycle.
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_ALL - WAIT_W'(1);

    logic [3:0]        state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              stall;
    logic              timeout;

    assign stall   = ((state_q == FETCH) || (state_q == MEMRD) || (state_q == MEMWR))
                     && !mem_ready;
    // This stalled cycle brings the count to all-ones: give up.
    assign timeout = stall && (wait_q == WAIT_LAST);

    // Next-state selection.
    always_comb begin
        state_d = FETCH;
        case (state_q)
            FETCH: begin
                if (timeout)        state_d = TRAP;
                else if (mem_ready) state_d = DECODE;
                else                state_d = FETCH;
            end
            DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_BEQ:       state_d = BEQ;
                    OP_BNE:       state_d = BNE;
                    OP_J:         state_d = JUMP;
                    OP_JAL:       state_d = JAL;
                    OP_RTYPE:     state_d = (funct == FN_JR) ? JR : EXEC;
                    OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI: state_d = EXEC;
                    default:      state_d = EXC_EN ? TRAP : EXEC;
                endcase
            end
            MEMADR: begin
                if (op == OP_LW)      state_d = MEMRD;
                else if (op == OP_SW) state_d = MEMWR;
                else                  state_d = FETCH;
            end
            MEMRD: begin
                if (timeout)        state_d = TRAP;
                else if (mem_ready) state_d = MEMWB;
                else                state_d = MEMRD;
            end
            MEMWR: begin
                if (timeout)        state_d = TRAP;
                else if (mem_ready) state_d = FETCH;
                else                state_d = MEMWR;
            end
            EXEC:    state_d = ALUWB;
            TRAP:    state_d = TRAP;
            default: state_d = FETCH;
        endcase
    end

    // Wait counter: counts consecutive stalled cycles within one state.
    always_comb begin
        wait_d = '0;
        if (stall && (state_d == state_q)) begin
            wait_d = wait_q + WAIT_W'(1);
        end
    end

    // State and wait-counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FETCH;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    // Moore outputs decoded from state; only fetch strobes and busy_wait see mem_ready.
    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        ALUSrcA     = 1'b0;
        RegWrite    = 1'b0;
        PCSource    = 2'b00;
        ALUOp       = 2'b00;
        ALUSrcB     = 2'b00;
        RegDst      = 2'b00;
        MemtoReg    = 2'b00;
        trap        = 1'b0;
        case (state_q)
            FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                IRWrite = mem_ready;
                PCWrite = mem_ready;
            end
            DECODE: ALUSrcB = 2'b11;
            MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            MEMRD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
            end
            MEMWB: begin
                RegWrite = 1'b1;
                MemtoReg = 2'b01;
            end
            MEMWR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
            end
            EXEC: begin
                ALUSrcA = 1'b1;
                ALUOp   = 2'b10;
                ALUSrcB = (op == OP_RTYPE) ? 2'b00 : 2'b10;
            end
            ALUWB: begin
                RegWrite = 1'b1;
                RegDst   = (op == OP_RTYPE) ? 2'b01 : 2'b00;
            end
            BEQ, BNE: begin
                ALUSrcA     = 1'b1;
                ALUOp       = (state_q == BEQ) ? 2'b01 : 2'b11;
                PCWriteCond = 1'b1;
                PCSource    = 2'b01;
            end
            JUMP: begin
                PCWrite  = 1'b1;
                PCSource = 2'b10;
            end
            JR: begin
                PCWrite  = 1'b1;
                PCSource = 2'b11;
            end
            JAL: begin
                PCWrite  = 1'b1;
                PCSource = 2'b10;
                RegWrite = 1'b1;
                RegDst   = 2'b10;
                MemtoReg = 2'b10;
            end
            TRAP:    trap = 1'b1;
            default: ;
        endcase
    end

    assign busy_wait = stall;
    assign state     = state_q;

endmodule
